router_ctrl_fsm: RTL and testbench

//  Packet-level controller for the 1xN router. Decodes the header address and

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_rd_timeout.sv | 45 ++++
 rtl/router_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_router_ctrl_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the 1xN router packet controller.
package router_pkg;

    // Header address field width and the reserved (never routable) code.
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Default read-timeout, in consecutive unread cycles, and the timer width it needs.
    localparam int TIMEOUT_DEFAULT = 30;
    localparam int CNT_W = $clog2(TIMEOUT_DEFAULT + 1);

    // Packet sequencing phases.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    // A header address is routable when it is not the reserved code and
    // names an output port that actually exists.
    function automatic logic addr_is_valid(input logic [ADDR_W-1:0] addr,
                                           input int num_ports);
        return (addr != ADDR_INVALID) && (int'(addr) < num_ports);
    endfunction

endpackage

// File: rtl/router_rd_timeout.sv
// Per-port read-timeout timer. Counts consecutive cycles in which the port
// holds data that the downstream reader does not take, and emits a single
// registered flush pulse once the reader has been silent for TIMEOUT cycles.
module router_rd_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic resetn,
    input  logic valid_out,
    input  logic read_enb,
    output logic soft_reset
);

    // Width is derived locally so an overridden TIMEOUT still fits.
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt;
    logic             unread;
    logic             expire;

    // Data is waiting and nobody is reading it this cycle.
    assign unread = valid_out && !read_enb;
    // Last counted cycle reached and the reader is still absent.
    assign expire = unread && (cnt == LAST);

    // Count unread cycles; restart on any read, on empty, or after firing.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= expire;
            if (!unread || expire) begin
                cnt <= '0;
            end else if (cnt != LAST) begin
                // Saturating increment: the counter never wraps.
                cnt <= cnt + TMR_W'(1);
            end
        end
    end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Packet-level controller for the 1xN router. Decodes the header address,
// sequences the byte register and output FIFOs through header, payload,
// parity and FIFO-full phases, drives source-side busy, and hosts one
// read-timeout timer per output port that flushes abandoned FIFOs.
module router_ctrl_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [1:0]           data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] valid_out,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [NUM_PORTS-1:0] soft_reset
);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic              we_int;

    // One independent read-timeout timer per output port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_tmr
        router_rd_timeout #(
            .TIMEOUT (TIMEOUT)
        ) u_tmr (
            .clock      (clock),
            .resetn     (resetn),
            .valid_out  (valid_out[p]),
            .read_enb   (read_enb[p]),
            .soft_reset (soft_reset[p])
        );
    end

    // State and latched destination register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
        end
    end

    // Next-state logic; a flush of the active destination abandons the packet.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        case (state)
            DECODE_ADDRESS: begin
                // Packets to unroutable addresses are simply never accepted.
                if (pkt_valid && addr_is_valid(data_in, NUM_PORTS)) begin
                    addr_nxt  = data_in;
                    state_nxt = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[addr_q]) begin
                    state_nxt = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: begin
                state_nxt = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (fifo_full[addr_q]) begin
                    state_nxt = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_nxt = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full[addr_q]) begin
                    state_nxt = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_nxt = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_nxt = LOAD_PARITY;
                end else begin
                    state_nxt = LOAD_DATA;
                end
            end
            LOAD_PARITY: begin
                state_nxt = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                state_nxt = fifo_full[addr_q] ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_nxt = DECODE_ADDRESS;
            end
        endcase

        // Flushed destination FIFO: drop whatever packet was in flight.
        if ((state != DECODE_ADDRESS) && soft_reset[addr_q]) begin
            state_nxt = DECODE_ADDRESS;
        end
    end

    // Moore output decode from the registered state and destination.
    always_comb begin
        busy        = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
        we_int      = 1'b0;
        write_enb   = '0;
        case (state)
            DECODE_ADDRESS:     detect_add = 1'b1;
            WAIT_TILL_EMPTY:    busy = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state = 1'b1;
                we_int   = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state = 1'b1;
                busy      = 1'b1;
                we_int    = 1'b1;
            end
            LOAD_PARITY: begin
                busy   = 1'b1;
                we_int = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: detect_add = 1'b1;
        endcase
        for (int i = 0; i < NUM_PORTS; i++) begin
            write_enb[i] = we_int && (addr_q == ADDR_W'(i));
        end
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for the router packet controller.
module tb_router_ctrl_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] valid_out;
    logic [2:0] read_enb;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [2:0] write_enb;
    logic [2:0] soft_reset;

    int checks = 0;
    int errors = 0;

    // Phase flags {detect_add, lfd, ld, laf, full, rst_int_reg}
    localparam logic [5:0] P_DEC  = 6'b100000;
    localparam logic [5:0] P_LFD  = 6'b010000;
    localparam logic [5:0] P_LD   = 6'b001000;
    localparam logic [5:0] P_LAF  = 6'b000100;
    localparam logic [5:0] P_FULL = 6'b000010;
    localparam logic [5:0] P_CPE  = 6'b000001;
    localparam logic [5:0] P_NONE = 6'b000000;

    router_ctrl_fsm #(
        .NUM_PORTS (3),
        .TIMEOUT   (30)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .valid_out     (valid_out),
        .read_enb      (read_enb),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb     (write_enb),
        .soft_reset    (soft_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic bsy, input logic [5:0] ph,
                         input logic [2:0] we);
        chk(tag,
            {6'd0, busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb},
            {6'd0, bsy, ph, we});
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'b00;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full     = 3'b000;
        fifo_empty    = 3'b111;
        valid_out     = 3'b000;
        read_enb      = 3'b000;
        #2;
        chk_o("reset_outs", 1'b0, P_DEC, 3'b000);
        chk("reset_soft", {13'd0, soft_reset}, 16'd0);
        #20;
        resetn = 1'b1;
        tick();
        chk_o("idle", 1'b0, P_DEC, 3'b000);

        // Header 0x0D: addr 1, three payload bytes, then parity
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        tick();
        chk_o("p1_lfd", 1'b1, P_LFD, 3'b000);
        tick();
        chk_o("p1_ld1", 1'b0, P_LD, 3'b010);
        tick();
        chk_o("p1_ld2", 1'b0, P_LD, 3'b010);
        tick();
        chk_o("p1_ld3", 1'b0, P_LD, 3'b010);
        pkt_valid = 1'b0;
        tick();
        chk_o("p1_parity", 1'b1, P_NONE, 3'b010);
        tick();
        chk_o("p1_chk", 1'b1, P_CPE, 3'b000);
        tick();
        chk_o("p1_done", 1'b0, P_DEC, 3'b000);

        // Invalid address 2'b11 is dropped
        pkt_valid = 1'b1;
        data_in   = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_o("bad_addr", 1'b0, P_DEC, 3'b000);
        end
        pkt_valid = 1'b0;

        // Addr 0 into a non-empty FIFO, then full mid-payload
        fifo_empty = 3'b110;
        pkt_valid  = 1'b1;
        data_in    = 2'b00;
        tick();
        chk_o("p3_wait1", 1'b1, P_NONE, 3'b000);
        tick();
        chk_o("p3_wait2", 1'b1, P_NONE, 3'b000);
        fifo_empty = 3'b111;
        tick();
        chk_o("p3_lfd", 1'b1, P_LFD, 3'b000);
        tick();
        chk_o("p3_ld", 1'b0, P_LD, 3'b001);
        fifo_full = 3'b001;
        tick();
        chk_o("p3_full1", 1'b1, P_FULL, 3'b000);
        tick();
        chk_o("p3_full2", 1'b1, P_FULL, 3'b000);
        fifo_full     = 3'b000;
        pkt_valid     = 1'b0;
        low_pkt_valid = 1'b1;
        tick();
        chk_o("p3_laf", 1'b1, P_LAF, 3'b001);
        tick();
        chk_o("p3_parity", 1'b1, P_NONE, 3'b001);
        low_pkt_valid = 1'b0;
        tick();
        chk_o("p3_chk", 1'b1, P_CPE, 3'b000);
        tick();
        chk_o("p3_done", 1'b0, P_DEC, 3'b000);

        // Port 2 left unread for 30 cycles
        valid_out = 3'b100;
        for (int i = 0; i < 29; i++) tick();
        chk("tmo_before", {13'd0, soft_reset}, 16'h0000);
        tick();
        chk("tmo_pulse", {13'd0, soft_reset}, 16'h0004);
        valid_out = 3'b000;
        tick();
        chk("tmo_after", {13'd0, soft_reset}, 16'h0000);

        // Same, but read on cycle 29
        valid_out = 3'b100;
        for (int i = 0; i < 28; i++) tick();
        read_enb = 3'b100;
        tick();
        read_enb = 3'b000;
        tick();
        chk("tmo_read30", {13'd0, soft_reset}, 16'h0000);
        tick();
        chk("tmo_read31", {13'd0, soft_reset}, 16'h0000);
        tick();
        chk("tmo_read32", {13'd0, soft_reset}, 16'h0000);
        valid_out = 3'b000;
        tick();

        // Soft reset of destination 2 while stalled full
        pkt_valid = 1'b1;
        data_in   = 2'b10;
        tick();
        chk_o("p5_lfd", 1'b1, P_LFD, 3'b000);
        tick();
        chk_o("p5_ld", 1'b0, P_LD, 3'b100);
        fifo_full = 3'b100;
        tick();
        chk_o("p5_full", 1'b1, P_FULL, 3'b000);
        pkt_valid = 1'b0;
        valid_out = 3'b100;
        for (int i = 0; i < 30; i++) tick();
        chk("p5_soft", {13'd0, soft_reset}, 16'h0004);
        chk_o("p5_still_full", 1'b1, P_FULL, 3'b000);
        tick();
        chk_o("p5_abandon", 1'b0, P_DEC, 3'b000);
        valid_out = 3'b000;
        fifo_full = 3'b000;
        tick();
        chk_o("p5_idle", 1'b0, P_DEC, 3'b000);

        // Asynchronous reset in LOAD_DATA
        pkt_valid = 1'b1;
        data_in   = 2'b01;
        tick();
        tick();
        chk_o("p6_ld", 1'b0, P_LD, 3'b010);
        #2;
        resetn = 1'b0;
        #1;
        chk_o("p6_async_rst", 1'b0, P_DEC, 3'b000);
        chk("p6_soft", {13'd0, soft_reset}, 16'h0000);
        pkt_valid = 1'b0;
        #4;
        resetn = 1'b1;
        tick();
        chk_o("p6_after", 1'b0, P_DEC, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
